// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// State encoding, default bus widths and read-latency counter sizing.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_MAX = 15;
  localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_lat_cnt.sv
// Load/decrement dwell counter with a zero flag; times the READ state.
// A load takes priority over a decrement; decrementing stops at zero.
module mem_lat_cnt
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic [LAT_CNT_W-1:0] cnt,
  output logic                 zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between AR/MBR and the image RAM; optional address
// bounds check enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 2,
  parameter int MEM_DEPTH = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [DATA_W-1:0] mbr_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mbr_load,
  output logic [DATA_W-1:0] mbr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              mem_err
);

  // Counter starts at RD_LAT-1 so the READ state lasts exactly RD_LAT cycles.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

  mem_state_e           state, next_state;
  logic                 req;
  logic                 req_oob;
  logic                 accept;
  logic                 is_rd_q;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [LAT_CNT_W-1:0] cnt_val;

  assign req    = mem_read | mem_write;
  assign accept = (state == ST_IDLE) && req;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
  logic err_q;

  assign req_oob = ({1'b0, ar_addr} >= DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_oob;
    end
  end
`else
  localparam int unused_mem_depth = MEM_DEPTH;
  assign req_oob = 1'b0;
`endif

  mem_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM strobes decode straight from state so a reset drops them immediately.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mem_busy   = 1'b1;
    mem_done   = 1'b0;
    mbr_load   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    mem_err    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        mem_busy = 1'b0;
        if (req) begin
          if (req_oob) begin
            next_state = ST_DONE;
          end else if (mem_write) begin
            next_state = ST_WRITE;
          end else begin
            next_state = ST_READ;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_READ: begin
        ram_en = 1'b1;
        if (cnt_zero) begin
          next_state = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WRITE: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        mem_done   = 1'b1;
        next_state = ST_IDLE;
`ifdef MEM_BOUNDS_CHECK_EN
        mem_err  = err_q;
        mbr_load = is_rd_q & ~err_q;
`else
        mbr_load = is_rd_q;
`endif
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Latched request copies; the AR/MBR buses are free to move once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      mbr_rdata <= '0;
      is_rd_q   <= 1'b0;
    end else begin
      if (accept) begin
        is_rd_q <= ~mem_write;
        if (!req_oob) begin
          ram_addr <= ar_addr;
          if (mem_write) begin
            ram_wdata <= mbr_wdata;
          end
        end
      end
      if ((state == ST_READ) && cnt_zero) begin
        mbr_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random accesses against a
// byte-array memory model; honours MEM_BOUNDS_CHECK_EN when defined.
module tb_mem_access_ctrl;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 16384;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ar_addr;
  logic [7:0]  mbr_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_busy;
  logic        mem_done;
  logic        mbr_load;
  logic [7:0]  mbr_rdata;
  logic [15:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        mem_err;

  // Bench-side RAM: one-cycle synchronous read, written on ram_en & ram_we.
  logic [7:0]  ram [0:65535] = '{default: 8'h00};
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_dat;

  // Reference: what memory should hold and what MBR should present.
  logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
  logic [7:0]  exp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
  end

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ar_addr   (ar_addr),
    .mbr_wdata (mbr_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mbr_load  (mbr_load),
    .mbr_rdata (mbr_rdata),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .mem_err   (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  // One request pulse, then follow it to completion and compare with the model.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input bit scramble, input string tag);
    int lat, en_n, we_n, exp_lat, exp_en;
    bit port_ok, oob;
    oob     = BOUNDS && (int'(addr) >= DEPTH);
    exp_lat = oob ? 1 : (wr ? 2 : RD_LAT + 1);
    exp_en  = oob ? 0 : (wr ? 1 : RD_LAT);
    ar_addr   = addr;
    mbr_wdata = wd;
    mem_read  = rd;
    mem_write = wr;
    step();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (scramble) begin
      ar_addr   = 16'($urandom);
      mbr_wdata = 8'($urandom);
    end
    lat = 1; en_n = 0; we_n = 0; port_ok = 1'b1;
    while (!mem_done && lat < 40) begin
      en_n += int'(ram_en);
      we_n += int'(ram_we);
      if (ram_en && ram_addr !== addr) port_ok = 1'b0;
      if (ram_we && ram_wdata !== wd) port_ok = 1'b0;
      step();
      lat++;
    end
    if (!oob) begin
      if (wr) ref_mem[addr] = wd;
      else    exp_rdata = ref_mem[addr];
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_en_cycles"}, en_n, exp_en);
    check({tag, "_we_cycles"}, we_n, (!oob && wr) ? 1 : 0);
    check({tag, "_ram_ports"}, port_ok, 1);
    check({tag, "_done_busy"}, mem_busy, 1);
    check({tag, "_mbr_load"}, mbr_load, (!oob && !wr) ? 1 : 0);
    check({tag, "_mem_err"}, mem_err, oob ? 1 : 0);
    check({tag, "_mbr_rdata"}, mbr_rdata, exp_rdata);
    step();
    check({tag, "_idle_after"}, {mem_busy, mem_done, ram_en}, 0);
  endtask

  initial begin
    int n, done_cnt, bad;
    bit addr_held;
    rst_n = 1'b0; ar_addr = '0; mbr_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    exp_rdata = 8'h00;
    #12;
    check("reset_outputs",
          {mem_busy, mem_done, mbr_load, mbr_rdata, ram_addr, ram_en, ram_we, ram_wdata, mem_err}, 0);
    preload(16'h0010, 8'hA5);
    preload(16'h0040, 8'h99);
    preload(16'h4000, 8'h5A);
    rst_n = 1'b1;
    step();

    access(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, "t1_read");
    check("t1_rdata_const", mbr_rdata, 8'hA5);
    access(1'b0, 1'b1, 16'h0020, 8'h3C, 1'b1, "t2_write");
    access(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, "t2_readback");
    check("t2_rdata_const", mbr_rdata, 8'h3C);
    access(1'b1, 1'b1, 16'h0030, 8'h77, 1'b0, "t3_both");
    check("t3_ram", ram[16'h0030], 8'h77);

    // Requests held high through READ and DONE must not start a second access.
    ar_addr = 16'h0010; mem_read = 1'b1;
    step();
    ar_addr = 16'h0055;
    n = 1; addr_held = 1'b1;
    while (!mem_done && n < 40) begin
      if (ram_addr !== 16'h0010) addr_held = 1'b0;
      step();
      n++;
    end
    done_cnt = int'(mem_done);
    step();
    mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done_cnt += int'(mem_done);
      if (mem_busy) addr_held = 1'b0;
      step();
    end
    exp_rdata = ref_mem[16'h0010];
    check("t4_latency", n, RD_LAT + 1);
    check("t4_one_done", done_cnt, 1);
    check("t4_addr_held", addr_held, 1);
    check("t4_rdata", mbr_rdata, exp_rdata);

    // Reset in the middle of a write aborts it.
    ar_addr = 16'h0040; mbr_wdata = 8'hEE; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    check("t5_we_before", ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_we_async", {ram_we, ram_en, mem_busy}, 0);
    #1 rst_n = 1'b1;
    exp_rdata = 8'h00;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      done_cnt += int'(mem_done);
    end
    check("t5_no_done", done_cnt, 0);
    check("t5_ram_untouched", ram[16'h0040], 8'h99);
    access(1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, "t5_readback");

    for (int k = 0; k < 24; k++) begin
      int op;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, 16'($urandom_range(0, 63)), 8'($urandom), 1'b1, "rand");
    end

    access(1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, "t6_bounds");

    bad = 0;
    for (int a = 0; a < 128; a++) if (ram[a] !== ref_mem[a]) bad++;
    check("final_ram_image", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
